// File: rtl/rom_sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer and the sample ROMs it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_sample_sequencer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DIV_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rom_sample_sequencer_tick_div.sv
// Sample-period divider: tick is high on the cycle the countdown sits at zero.
// Latency: tick is combinational from the counter; load takes effect next edge.
// Backpressure: none; enable low freezes the count.
module sample_tick_div
    import rom_sample_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    assign tick = enable && (count == '0);

    // Reload on request, otherwise count down to zero and park there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/rom_sample_sequencer.sv
// Plays a sample table out of an external synchronous ROM at a programmable rate.
// Latency: each sample emerges two edges after its ROM address is issued.
// Backpressure: none; stop ends address issue and all in-flight samples drain.
module rom_sample_sequencer
    import rom_sample_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [DIV_WIDTH-1:0]         clk_div,
    input  logic [ADDR_WIDTH-1:0]        last_addr,
    input  logic                         loop_en,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic signed [DATA_WIDTH-1:0] rom_data,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         done
);

    seq_state_t             state;
    logic [DIV_WIDTH-1:0]   cfg_div;
    logic [ADDR_WIDTH-1:0]  cfg_last;
    logic                   cfg_loop;
    logic                   addr_vld;   // address issued last edge, ROM reading it
    logic                   data_vld;   // ROM output now holds an issued sample
    logic                   tick;
    logic                   run_issue;
    logic                   div_load;
    logic [DIV_WIDTH-1:0]   div_load_val;
    logic [ADDR_WIDTH-1:0]  next_addr;

    // Next table address: wrap to the start only when looping.
    always_comb begin
        next_addr = rom_addr + 1'b1;
        if (cfg_loop && (rom_addr == cfg_last)) begin
            next_addr = '0;
        end
    end

    // stop takes priority over a pending tick.
    assign run_issue    = (state == ST_RUN) && !stop && tick;
    assign div_load     = ((state == ST_IDLE) && start) || run_issue;
    assign div_load_val = (state == ST_IDLE) ? clk_div : cfg_div;
    assign busy         = (state != ST_IDLE);

    sample_tick_div #(
        .WIDTH(DIV_WIDTH)
    ) u_tick_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .load_val (div_load_val),
        .enable   (state == ST_RUN),
        .tick     (tick)
    );

    // Playback FSM, address issue and the two-stage sample valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cfg_div      <= '0;
            cfg_last     <= '0;
            cfg_loop     <= 1'b0;
            rom_addr     <= '0;
            addr_vld     <= 1'b0;
            data_vld     <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            addr_vld     <= 1'b0;
            data_vld     <= addr_vld;
            sample_valid <= data_vld;
            if (data_vld) begin
                sample_out <= rom_data;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_div  <= clk_div;
                        cfg_last <= last_addr;
                        cfg_loop <= loop_en;
                        rom_addr <= '0;
                        addr_vld <= 1'b1;
                        // A one-entry, non-looping table is finished on issue.
                        state    <= ((last_addr == '0) && !loop_en) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_DRAIN;
                    end else if (tick) begin
                        rom_addr <= next_addr;
                        addr_vld <= 1'b1;
                        if (!cfg_loop && (next_addr == cfg_last)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Once no address is still in the ROM, the sample in data_vld
                    // (if any) is the final one and strobes together with done.
                    if (!addr_vld) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
